// File: rtl/effect_peq_tdm_if.sv
// Sample/coefficient bus for the time-multiplexed parametric EQ.
// The master drives samples and coefficient writes; the slave returns results and status.
interface effect_peq_tdm_if #(
  parameter int unsigned N_BANDS = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEF_W  = 32
);
  localparam int unsigned ADDR_W = $clog2(5 * N_BANDS);

  logic                     i_valid;
  logic                     i_enable;
  logic signed [DATA_W-1:0] i_data;
  logic                     i_coef_we;
  logic        [ADDR_W-1:0] i_coef_addr;
  logic signed [COEF_W-1:0] i_coef_wdata;
  logic                     i_coef_commit;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_valid;
  logic                     o_busy;
  logic                     o_drop;

  modport master (
    output i_valid, i_enable, i_data, i_coef_we, i_coef_addr, i_coef_wdata, i_coef_commit,
    input  o_data, o_valid, o_busy, o_drop
  );

  modport slave (
    input  i_valid, i_enable, i_data, i_coef_we, i_coef_addr, i_coef_wdata, i_coef_commit,
    output o_data, o_valid, o_busy, o_drop
  );
endinterface

// File: rtl/effect_peq_tdm.sv
// Cascaded biquad parametric EQ sharing one multiplier over all taps and bands,
// with a shadow/active coefficient bank pair and a bypass path.
module effect_peq_tdm #(
  parameter int unsigned N_BANDS = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEF_W  = 32,
  parameter int unsigned FRAC    = 28
) (
  input logic            i_clk,
  input logic            i_rst_n,
  effect_peq_tdm_if.slave bus
);
  localparam int unsigned NCoef = 5 * N_BANDS;
  localparam int unsigned AddrW = $clog2(NCoef);
  localparam int unsigned BandW = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam int unsigned ProdW = DATA_W + COEF_W;
  localparam int unsigned AccW  = ProdW + 3;
  localparam logic [COEF_W-1:0] CoefOne = COEF_W'(1) << FRAC;

  typedef enum logic [1:0] {StIdle, StMac, StSat} state_e;

  state_e state_q, state_d;
  logic [BandW-1:0] band_q;
  logic [2:0]       tap_q;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0] xin_q, data_q;
  logic                     valid_q;
  logic signed [DATA_W-1:0] x1_q [N_BANDS];
  logic signed [DATA_W-1:0] x2_q [N_BANDS];
  logic signed [DATA_W-1:0] y1_q [N_BANDS];
  logic signed [DATA_W-1:0] y2_q [N_BANDS];
  logic signed [COEF_W-1:0] coef_sh_q  [NCoef];
  logic signed [COEF_W-1:0] coef_act_q [NCoef];
  logic                     commit_pend_q;

  logic capture, last_band, commit_req, do_copy;
  logic [AddrW-1:0]         coef_idx;
  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W-1:0] op;
  logic signed [ProdW-1:0]  prod;
  logic signed [AccW-1:0]   prod_ext, acc_sh;
  logic [AccW-DATA_W:0]     acc_upper;
  logic                     ovf;
  logic signed [DATA_W-1:0] sat_y;

  assign capture    = (state_q == StIdle) && bus.i_valid && bus.i_enable;
  assign last_band  = (band_q == BandW'(N_BANDS - 1));
  assign commit_req = commit_pend_q | bus.i_coef_commit;
  // A capture on the same edge keeps the old bank for that sample.
  assign do_copy    = (state_q == StIdle) && !capture && commit_req;

  assign coef_idx = AddrW'(5 * 32'(band_q) + 32'(tap_q));
  assign coef     = coef_act_q[coef_idx];

  always_comb begin
    op = '0;
    case (tap_q)
      3'd0:    op = xin_q;
      3'd1:    op = x1_q[band_q];
      3'd2:    op = x2_q[band_q];
      3'd3:    op = y1_q[band_q];
      3'd4:    op = y2_q[band_q];
      default: op = '0;
    endcase
  end

  // Full sign extension makes the unsigned product bit-exact for signed operands.
  assign prod     = {{COEF_W{op[DATA_W-1]}}, op} * {{DATA_W{coef[COEF_W-1]}}, coef};
  assign prod_ext = {{3{prod[ProdW-1]}}, prod};
  assign acc_d    = (tap_q >= 3'd3) ? acc_q - prod_ext : acc_q + prod_ext;

  assign acc_sh    = acc_q >>> FRAC;
  assign acc_upper = acc_sh[AccW-1:DATA_W-1];
  assign ovf       = !((&acc_upper) || !(|acc_upper));
  assign sat_y     = ovf ? (acc_sh[AccW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                          : {1'b0, {(DATA_W-1){1'b1}}})
                         : acc_sh[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    if (!bus.i_enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.i_valid) state_d = StMac;
        StMac:   if (tap_q == 3'd4) state_d = StSat;
        StSat:   state_d = last_band ? StIdle : StMac;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      band_q  <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      xin_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      for (int b = 0; b < N_BANDS; b++) begin
        x1_q[b] <= '0;
        x2_q[b] <= '0;
        y1_q[b] <= '0;
        y2_q[b] <= '0;
      end
    end else if (!bus.i_enable) begin
      band_q  <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      for (int b = 0; b < N_BANDS; b++) begin
        x1_q[b] <= '0;
        x2_q[b] <= '0;
        y1_q[b] <= '0;
        y2_q[b] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_valid) begin
            xin_q  <= bus.i_data;
            band_q <= '0;
            tap_q  <= '0;
            acc_q  <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_d;
          tap_q <= tap_q + 3'd1;
        end
        StSat: begin
          x2_q[band_q] <= x1_q[band_q];
          x1_q[band_q] <= xin_q;
          y2_q[band_q] <= y1_q[band_q];
          y1_q[band_q] <= sat_y;
          xin_q        <= sat_y;
          acc_q        <= '0;
          tap_q        <= '0;
          if (last_band) begin
            data_q  <= sat_y;
            valid_q <= 1'b1;
          end else begin
            band_q <= band_q + BandW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCoef; i++) begin
        coef_sh_q[i]  <= (i % 5 == 0) ? CoefOne : '0;
        coef_act_q[i] <= (i % 5 == 0) ? CoefOne : '0;
      end
      commit_pend_q <= 1'b0;
    end else begin
      if (bus.i_coef_we && (32'(bus.i_coef_addr) < NCoef)) begin
        coef_sh_q[bus.i_coef_addr] <= bus.i_coef_wdata;
      end
      if (do_copy) coef_act_q <= coef_sh_q;
      commit_pend_q <= commit_req && !do_copy;
    end
  end

  assign bus.o_data  = bus.i_enable ? data_q : bus.i_data;
  assign bus.o_valid = bus.i_enable ? valid_q : bus.i_valid;
  assign bus.o_busy  = (state_q != StIdle);
  assign bus.o_drop  = bus.i_enable && bus.i_valid && (state_q != StIdle);
endmodule

// File: doc/effect_peq_tdm.md
EFFECT_PEQ_TDM -- requirements
Module: effect_peq_tdm

Interface
REQ-001 SHALL have parameter N_BANDS, default 4, giving the number of cascaded biquad bands (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, giving the signed audio sample width.
REQ-003 SHALL have parameter COEF_W, default 32, giving the signed coefficient width.
REQ-004 SHALL have parameter FRAC, default 28, giving the coefficient fractional bits (Q(COEF_W-FRAC).FRAC).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 i_clk  input  1  sole clock, rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_valid  input  1  one-cycle strobe, i_data holds a new sample.
REQ-009 i_enable  input  1  1 = filter, 0 = bypass.
REQ-010 i_data  input  DATA_W  signed input sample.
REQ-011 i_coef_we  input  1  write strobe to the shadow coefficient bank.
REQ-012 i_coef_addr  input  clog2(5*N_BANDS)  index = band*5 + tap; tap 0..4 = a0,a1,a2,b1,b2.
REQ-013 i_coef_wdata  input  COEF_W  signed coefficient write data.
REQ-014 i_coef_commit  input  1  one-cycle request to copy the shadow bank to the active bank.
REQ-015 o_data  output  DATA_W  signed output sample.
REQ-016 o_valid  output  1  one-cycle strobe, o_data valid.
REQ-017 o_busy  output  1  sample in flight.
REQ-018 o_drop  output  1  one-cycle pulse, an input sample was discarded.

Function
REQ-019 SHALL compute per band y = a0*x + a1*x1 + a2*x2 - b1*y1 - b2*y2, arithmetic shift right by FRAC, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; band k output is band k+1 input.
REQ-020 SHALL use exactly one DATA_W x COEF_W signed multiplier, time-shared over all taps and bands.
REQ-021 SHALL use an accumulator of DATA_W+COEF_W+3 bits, cleared at the start of each band; no internal wrap is permitted.
REQ-022 SHALL implement FSM states IDLE, MAC, SAT: IDLE -> MAC on i_valid && i_enable, latching i_data, band=0, tap=0; MAC accumulates one tap per cycle, tap 0..4; MAC -> SAT after tap 4; SAT saturates and updates that band's x1,x2,y1,y2; SAT -> MAC with band+1, or SAT -> IDLE for the last band.
REQ-023 SHALL register o_data and pulse o_valid high in the cycle after the last SAT edge; latency = 6*N_BANDS edges from the capture edge (24 for default).
REQ-024 o_busy SHALL be high from the capture edge until the edge that raises o_valid.
REQ-025 i_valid while o_busy SHALL NOT disturb processing; the sample is discarded and o_drop pulses for one cycle.
REQ-026 i_coef_we SHALL write the shadow bank in any state; the active bank is never read-modified by writes.
REQ-027 i_coef_commit SHALL set a pending flag; the copy occurs on the first edge with the FSM in IDLE and no capture that edge; a capture and commit on the same IDLE edge processes the sample with the old bank.
REQ-028 When i_enable=0: o_data = i_data and o_valid = i_valid combinationally, o_drop=0, the FSM is forced to IDLE (in-flight sample aborted, no o_valid), and all band histories are cleared.
REQ-029 Saturation SHALL apply per band; a saturated value is stored to y1.

Reset
REQ-030 On reset: FSM IDLE, o_data=0, o_valid=0, o_busy=0, o_drop=0, histories 0, commit-pending 0.
REQ-031 On reset both banks SHALL load flat: a0 = 2^FRAC, a1=a2=b1=b2=0 for every band.
REQ-032 Reset asserted mid-sample SHALL abort with no o_valid after release.

Verification
REQ-033 Reset, i_enable=1, i_data=1000 -> o_valid 24 edges later, o_data=1000; o_busy high 24 cycles.
REQ-034 Band 0 a0=2^30 committed, i_data=20000 -> o_data=32767; i_data=-20000 -> o_data=-32768.
REQ-035 Band 0 a0=2^27, b1=-2^27 (y=0.5x+0.5y1), impulse 1024 then zeros -> o_data 512, 256, 128, ...
REQ-036 Second i_valid 5 cycles after first -> single o_valid, o_drop pulse at that cycle.
REQ-037 Commit issued while busy -> in-flight sample uses old bank; next sample uses new bank.
REQ-038 i_enable dropped mid-sample -> no filtered o_valid, o_data follows i_data; re-enable with impulse -> clean response from zero state.
